// File: rtl/eth_tx_frame_arb.sv
// Frame-granular round-robin arbiter in front of a single MAC tx AXI-stream port.
// A granted source owns the MAC until its tlast beat is accepted. A watchdog aborts a
// frame whose source goes idle mid-frame: it emits an error-marked tlast beat to the MAC,
// then drains the rest of that frame from the source.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   s_axis_*             S_COUNT packed source streams (port i at [i*W +: W])
//   m_axis_*             stream to the MAC tx_axis port
//   enable               permits new grants; an owned frame always completes
//   grant, grant_valid   one-hot current owner / a frame is owned
//   timeout_event        one-cycle pulse as an abort starts
//   timeout_src          index of the most recently aborted source
module eth_tx_frame_arb #(
  parameter int unsigned S_COUNT    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  input  logic                          enable,
  output logic [S_COUNT-1:0]            grant,
  output logic                          grant_valid,
  output logic                          timeout_event,
  output logic [$clog2(S_COUNT)-1:0]    timeout_src
);

  localparam int unsigned IdxW = $clog2(S_COUNT);
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StXfer, StAbort, StDrop} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [IdxW-1:0] to_src_q, to_src_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            to_evt_q, to_evt_d;

  // Currently granted source, selected from the packed buses.
  logic [DATA_WIDTH-1:0] g_data;
  logic [USER_WIDTH-1:0] g_user;
  logic                  g_valid;
  logic                  g_last;

  assign g_data  = s_axis_tdata[gnt_q*DATA_WIDTH +: DATA_WIDTH];
  assign g_user  = s_axis_tuser[gnt_q*USER_WIDTH +: USER_WIDTH];
  assign g_valid = s_axis_tvalid[gnt_q];
  assign g_last  = s_axis_tlast[gnt_q];

  // Round-robin pick: first requester above the last owner, wrapping.
  logic [IdxW-1:0] cand;
  logic [IdxW-1:0] pick;
  logic            pick_vld;

  always_comb begin
    cand     = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned i = 1; i <= S_COUNT; i++) begin
      cand = IdxW'((32'(last_q) + i) % S_COUNT);
      if (!pick_vld && s_axis_tvalid[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      last_q   <= IdxW'(S_COUNT - 1);
      to_src_q <= '0;
      cnt_q    <= '0;
      to_evt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      to_src_q <= to_src_d;
      cnt_q    <= cnt_d;
      to_evt_q <= to_evt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    to_src_d = to_src_q;
    cnt_d    = cnt_q;
    to_evt_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (enable && pick_vld) begin
          gnt_d   = pick;
          cnt_d   = '0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (g_valid && m_axis_tready) begin
          cnt_d = '0;
          if (g_last) begin
            last_d  = gnt_q;
            state_d = StIdle;
          end
        end else if (!g_valid && (TIMEOUT != 0)) begin
          // Only source-idle cycles count; MAC backpressure never aborts a frame.
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CntW'(TIMEOUT)) begin
            state_d  = StAbort;
            to_evt_d = 1'b1;
            to_src_d = gnt_q;
          end
        end
      end
      StAbort: begin
        if (m_axis_tready) state_d = StDrop;
      end
      StDrop: begin
        if (g_valid && g_last) begin
          last_d  = gnt_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = '0;
    grant         = '0;
    grant_valid   = 1'b0;
    case (state_q)
      StXfer: begin
        m_axis_tdata         = g_data;
        m_axis_tvalid        = g_valid;
        m_axis_tlast         = g_last;
        m_axis_tuser         = g_user;
        s_axis_tready[gnt_q] = m_axis_tready;
      end
      StAbort: begin
        // Error-marked tlast so the MAC discards the truncated frame.
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tuser  = USER_WIDTH'(1);
      end
      StDrop: begin
        s_axis_tready[gnt_q] = 1'b1;
      end
      default: ;
    endcase
    if (state_q != StIdle) begin
      grant[gnt_q] = 1'b1;
      grant_valid  = 1'b1;
    end
  end

  assign timeout_event = to_evt_q;
  assign timeout_src   = to_src_q;

endmodule

// File: tb/tb_eth_tx_frame_arb.sv
// Self-checking bench for eth_tx_frame_arb: per-source frame tables drive the sources,
// a frame-level scoreboard checks every frame emitted on m_axis against the table entry
// of its owner, and each grant is checked against the round-robin rule.
module tb_eth_tx_frame_arb;

  localparam int S       = 4;
  localparam int DW      = 8;
  localparam int UW      = 1;
  localparam int TO      = 16;
  localparam int IW      = $clog2(S);
  localparam int NF      = 6;
  localparam int ML      = 8;
  localparam int LongGap = 24;

  logic clk = 1'b0;
  logic rst;
  logic [S*DW-1:0] s_tdata;
  logic [S-1:0]    s_tvalid, s_tready, s_tlast;
  logic [S*UW-1:0] s_tuser;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid, m_tready, m_tlast;
  logic [UW-1:0]   m_tuser;
  logic            enable;
  logic [S-1:0]    grant;
  logic            grant_valid, timeout_event;
  logic [IW-1:0]   timeout_src;

  eth_tx_frame_arb #(
    .S_COUNT(S), .DATA_WIDTH(DW), .USER_WIDTH(UW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .enable(enable), .grant(grant), .grant_valid(grant_valid),
    .timeout_event(timeout_event), .timeout_src(timeout_src)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame plan per source.
  int          nfr    [S];
  int          flen   [S][NF];
  int          fstall [S][NF];  // beats sent before a long stall, 0 = no stall
  logic [DW-1:0] fdat [S][NF][ML];
  logic        fusr   [S][NF][ML];
  int          nstall;

  // Source driver state.
  int src_f [S];
  int src_b [S];
  int src_gap [S];
  bit short_gaps;
  int rdy_pct, blk_after, blk_left, en_drop_after;
  bit en_rand;

  // Reference model / scoreboard state.
  int          exp_f [S];
  int          last_owner;
  logic [S-1:0] fire, prev_req;
  logic        prev_gv, prev_en;
  logic [DW-1:0] obs_d[$];
  logic        obs_u[$];
  logic [S-1:0] obs_g[$];
  logic [S-1:0] ghist[$];
  int          beat_cyc[$];
  int          cyc, frames_out, tev, tev_cyc, beats_seen;

  task automatic model_reset();
    last_owner = S - 1;
    prev_gv    = 1'b0;
    prev_en    = 1'b0;
    prev_req   = '0;
  endtask

  task automatic clear_plan();
    for (int s = 0; s < S; s++) begin
      nfr[s] = 0; src_f[s] = 0; src_b[s] = 0; src_gap[s] = 0; exp_f[s] = 0;
    end
    obs_d.delete(); obs_u.delete(); obs_g.delete(); ghist.delete(); beat_cyc.delete();
    frames_out = 0; tev = 0; nstall = 0; beats_seen = 0; tev_cyc = 0;
    short_gaps = 0; rdy_pct = 100; blk_after = 0; blk_left = 0; en_drop_after = 0;
    en_rand = 0; fire = '0;
  endtask

  task automatic add_frame(input int s, input int len, input int stall);
    int f;
    f = nfr[s];
    flen[s][f]   = len;
    fstall[s][f] = stall;
    for (int b = 0; b < len; b++) begin
      fdat[s][f][b] = DW'($urandom);
      fusr[s][f][b] = 1'($urandom_range(1));
    end
    nfr[s]++;
    if (stall != 0) nstall++;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_grant_valid"}, grant_valid, 0);
    check({tag, "_s_tready"}, s_tready, 0);
    check({tag, "_m_tvalid"}, m_tvalid, 0);
    check({tag, "_m_tlast"}, m_tlast, 0);
    check({tag, "_m_tdata"}, m_tdata, 0);
    check({tag, "_m_tuser"}, m_tuser, 0);
    check({tag, "_tevent"}, timeout_event, 0);
    check({tag, "_tsrc"}, timeout_src, 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; enable = 1'b0; m_tready = 1'b0;
    s_tvalid = '0; s_tdata = '0; s_tlast = '0; s_tuser = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero(tag);
    rst = 1'b0;
    model_reset();
  endtask

  // Present source beats and MAC ready, using the handshakes sampled last cycle.
  task automatic drive();
    for (int i = 0; i < S; i++) begin
      if (fire[i]) begin
        src_b[i]++;
        if (src_b[i] == flen[i][src_f[i]]) begin
          src_f[i]++;
          src_b[i]   = 0;
          src_gap[i] = short_gaps ? int'($urandom_range(2)) : 0;
        end else if (src_b[i] == fstall[i][src_f[i]]) begin
          src_gap[i] = LongGap;
        end else begin
          src_gap[i] = short_gaps ? int'($urandom_range(3)) : 0;
        end
      end else if (src_gap[i] > 0) begin
        src_gap[i]--;
      end
      if (src_f[i] < nfr[i] && src_gap[i] == 0) begin
        s_tvalid[i]          = 1'b1;
        s_tdata[i*DW +: DW]  = fdat[i][src_f[i]][src_b[i]];
        s_tlast[i]           = (src_b[i] == flen[i][src_f[i]] - 1);
        s_tuser[i*UW +: UW]  = UW'(fusr[i][src_f[i]][src_b[i]]);
      end else begin
        s_tvalid[i]          = 1'b0;
        s_tdata[i*DW +: DW]  = '0;
        s_tlast[i]           = 1'b0;
        s_tuser[i*UW +: UW]  = '0;
      end
    end
    if (blk_left > 0 && beats_seen >= blk_after) begin
      m_tready = 1'b0;
      blk_left--;
    end else begin
      m_tready = (int'($urandom_range(99)) < rdy_pct);
    end
    if (en_drop_after > 0 && beats_seen >= en_drop_after) enable = 1'b0;
    else if (en_rand) enable = ($urandom_range(9) != 0);
  endtask

  task automatic start();
    fire = '0;
    drive();
  endtask

  task automatic end_frame();
    int o, f, n;
    logic [DW-1:0] ed;
    logic eu;
    o = last_owner;
    f = exp_f[o];
    check("frame_expected", f < nfr[o], 1);
    if (f < nfr[o]) begin
      n = (fstall[o][f] != 0) ? fstall[o][f] + 1 : flen[o][f];
      check("frame_len", obs_d.size(), n);
      for (int i = 0; i < obs_d.size() && i < n; i++) begin
        if (fstall[o][f] != 0 && i == n - 1) begin
          ed = '0; eu = 1'b1;
        end else begin
          ed = fdat[o][f][i]; eu = fusr[o][f][i];
        end
        check("beat_data", obs_d[i], ed);
        check("beat_user", obs_u[i], eu);
        check("beat_owner", obs_g[i], 1 << o);
      end
      exp_f[o]++;
    end
    frames_out++;
    obs_d.delete(); obs_u.delete(); obs_g.delete();
  endtask

  task automatic monitor();
    int w;
    fire = s_tvalid & s_tready;
    if (!prev_gv) check("grant_rise", grant_valid, prev_en && (prev_req != 0));
    if (grant_valid && !prev_gv) begin
      w = last_owner;
      for (int k = S; k >= 1; k--) if (prev_req[(last_owner + k) % S]) w = (last_owner + k) % S;
      check("rr_grant", grant, 1 << w);
      ghist.push_back(grant);
      last_owner = w;
    end
    if (timeout_event) begin
      tev++;
      tev_cyc = cyc;
      check("to_src", timeout_src, last_owner);
      check("to_planned", (exp_f[last_owner] < nfr[last_owner]) &&
            (fstall[last_owner][exp_f[last_owner]] != 0), 1);
    end
    if (m_tvalid && m_tready) begin
      obs_d.push_back(m_tdata);
      obs_u.push_back(m_tuser[0]);
      obs_g.push_back(grant);
      beat_cyc.push_back(cyc);
      beats_seen++;
      if (m_tlast) end_frame();
    end
    prev_gv  = grant_valid;
    prev_en  = enable;
    prev_req = s_tvalid;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  function automatic bit all_done();
    bit d = !grant_valid;
    for (int s = 0; s < S; s++) if (src_f[s] != nfr[s] || exp_f[s] != nfr[s]) d = 0;
    return d;
  endfunction

  task automatic run_done(input int budget, input string tag);
    int n = 0;
    while (!all_done() && n < budget) begin
      step();
      n++;
    end
    check(tag, all_done(), 1);
  endtask

  initial begin
    #900000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int len, stl, n;
    cyc = 0;
    clear_plan();
    do_reset("reset");

    // Ports 0 and 2 each send a 4-beat frame back to back.
    clear_plan();
    add_frame(0, 4, 0); add_frame(2, 4, 0);
    enable = 1'b1;
    start();
    run_done(100, "s1_done");
    check("s1_ngrants", ghist.size(), 2);
    if (ghist.size() == 2) begin
      check("s1_grant0", ghist[0], 4'b0001);
      check("s1_grant1", ghist[1], 4'b0100);
    end
    check("s1_beats", beat_cyc.size(), 8);
    if (beat_cyc.size() == 8) begin
      check("s1_burst", beat_cyc[3] - beat_cyc[0], 3);
      check("s1_idle_gap", beat_cyc[4] - beat_cyc[3], 2);
    end

    // All ports continuously requesting 2-beat frames.
    do_reset("rst2");
    clear_plan();
    for (int s = 0; s < S; s++) begin
      add_frame(s, 2, 0); add_frame(s, 2, 0);
    end
    enable = 1'b1;
    start();
    run_done(200, "s2_done");
    check("s2_ngrants", ghist.size(), 8);
    for (int i = 0; i < ghist.size(); i++) check("s2_order", ghist[i], 1 << (i % S));

    // Long MAC backpressure mid-frame must not abort.
    do_reset("rst3");
    clear_plan();
    add_frame(1, 6, 0);
    blk_after = 2; blk_left = 40;
    enable = 1'b1;
    start();
    run_done(200, "s3_done");
    check("s3_timeouts", tev, 0);
    check("s3_frames", frames_out, 1);
    if (beat_cyc.size() >= 3) check("s3_stall_len", beat_cyc[2] - beat_cyc[1], 41);

    // Port 3 stalls after 2 of 6 beats: abort, then drain.
    do_reset("rst4");
    clear_plan();
    add_frame(3, 6, 2);
    enable = 1'b1;
    start();
    run_done(200, "s4_done");
    check("s4_timeouts", tev, 1);
    check("s4_src", timeout_src, 3);
    check("s4_out_beats", beat_cyc.size(), 3);
    if (beat_cyc.size() >= 2) check("s4_abort_delay", tev_cyc - beat_cyc[1], TO + 1);
    check("s4_frames", frames_out, 1);

    // enable low blocks grants; enable falling mid-frame lets the frame finish.
    do_reset("rst5");
    clear_plan();
    for (int s = 0; s < S; s++) add_frame(s, 3, 0);
    start();
    repeat (30) step();
    check("s5_no_grant", ghist.size(), 0);
    enable = 1'b1;
    en_drop_after = 1;
    repeat (40) step();
    check("s5_frames", frames_out, 1);
    check("s5_ngrants", ghist.size(), 1);
    check("s5_idle", grant_valid, 0);

    // Asynchronous reset in the middle of a frame.
    do_reset("rst6");
    clear_plan();
    add_frame(0, 2, 0); add_frame(1, 3, 0); add_frame(2, 8, 0);
    enable = 1'b1;
    start();
    n = 0;
    while (frames_out < 2 && n < 100) begin
      step();
      n++;
    end
    repeat (3) step();
    check("s6_midframe", grant, 4'b0100);
    #2 rst = 1'b1;
    #1 check_zero("arst");
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    clear_plan();
    for (int s = 0; s < S; s++) add_frame(s, 2, 0);
    enable = 1'b1;
    start();
    run_done(200, "s6_done");
    if (ghist.size() > 0) check("s6_first", ghist[0], 4'b0001);
    else check("s6_first", 0, 4'b0001);

    // Randomized traffic: gaps, backpressure, enable toggling and planned stalls.
    for (int r = 0; r < 3; r++) begin
      clear_plan();
      for (int s = 0; s < S; s++) begin
        for (int f = 0; f < NF; f++) begin
          len = int'($urandom_range(1, ML));
          stl = (len >= 2 && $urandom_range(4) == 0) ? int'($urandom_range(1, len - 1)) : 0;
          add_frame(s, len, stl);
        end
      end
      short_gaps = 1; rdy_pct = 75; en_rand = 1; enable = 1'b1;
      start();
      run_done(8000, "rand_done");
      check("rand_timeouts", tev, nstall);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
